// File: rtl/dht_pkg.sv
// Shared codes, state encoding and data types for the DHT11 request server.
package dht_pkg;

    localparam logic [7:0] REQ_STATUS    = 8'h00;
    localparam logic [7:0] REQ_TEMP_INT  = 8'h01;
    localparam logic [7:0] REQ_HUM_INT   = 8'h02;
    localparam logic [7:0] REQ_TEMP_FRAC = 8'h03;
    localparam logic [7:0] REQ_HUM_FRAC  = 8'h04;

    localparam logic [7:0] RSP_OK         = 8'h07;
    localparam logic [7:0] RSP_TEMP_INT   = 8'h08;
    localparam logic [7:0] RSP_HUM_INT    = 8'h09;
    localparam logic [7:0] RSP_TEMP_FRAC  = 8'h0A;
    localparam logic [7:0] RSP_HUM_FRAC   = 8'h0B;
    localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;
    localparam logic [7:0] RSP_CSUM_ERR   = 8'h2F;
    localparam logic [7:0] RSP_INVALID    = 8'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StStart,
        StWaitDone,
        StCheck,
        StSend0,
        StSend1
    } state_e;

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_float;
        logic [7:0] temp_int;
        logic [7:0] temp_float;
        logic [7:0] check_sum;
    } dht_data_t;

    function automatic logic checksum_ok(input dht_data_t d);
        logic [7:0] sum;
        sum = d.hum_int + d.hum_float + d.temp_int + d.temp_float;
        return sum == d.check_sum;
    endfunction

    function automatic logic code_valid(input logic [7:0] code);
        return code <= REQ_HUM_FRAC;
    endfunction

    function automatic logic [7:0] rsp_code(input logic [7:0] code);
        case (code)
            REQ_STATUS:    return RSP_OK;
            REQ_TEMP_INT:  return RSP_TEMP_INT;
            REQ_HUM_INT:   return RSP_HUM_INT;
            REQ_TEMP_FRAC: return RSP_TEMP_FRAC;
            REQ_HUM_FRAC:  return RSP_HUM_FRAC;
            default:       return RSP_INVALID;
        endcase
    endfunction

    function automatic logic [7:0] rsp_value(input dht_data_t d, input logic [7:0] code);
        case (code)
            REQ_TEMP_INT:  return d.temp_int;
            REQ_HUM_INT:   return d.hum_int;
            REQ_TEMP_FRAC: return d.temp_float;
            REQ_HUM_FRAC:  return d.hum_float;
            default:       return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/dht_age_timer.sv
// Saturating age counter for the cached reading; stale once age reaches CACHE_TIME.
module dht_age_timer #(
    parameter int unsigned AGE_W      = 22,
    parameter int unsigned CACHE_TIME = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic stale
);

    logic [AGE_W-1:0] age_q;

    assign stale = age_q >= AGE_W'(CACHE_TIME);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (clear) begin
            age_q <= '0;
        end else if (enable && !stale) begin
            age_q <= age_q + AGE_W'(1);
        end
    end

endmodule

// File: rtl/dht_request_server.sv
// Serves one-byte measurement requests from a cached DHT11 reading or a fresh
// driver read, answering with a two-byte (code, value) stream.
module dht_request_server
    import dht_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 25000,
    parameter int unsigned CACHE_TIME   = 2000000,
    parameter int unsigned AGE_W        = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [7:0] req_code,
    output logic       req_ready,
    output logic       dht_start,
    input  logic       dht_done,
    input  logic       dht_error,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic [7:0] check_sum,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int unsigned TO_W = $clog2(DONE_TIMEOUT + 1);

    state_e          state_q;
    logic [7:0]      code_q;
    logic [7:0]      byte1_q;
    logic [TO_W-1:0] cnt_q;
    dht_data_t       data_q;
    logic            err_q;
    logic            cache_valid_q;
    logic            cache_stale;
    logic            csum_ok;
    logic            age_clear;

    // data_q doubles as the cache: every fresh read either validates or invalidates it
    assign csum_ok   = checksum_ok(data_q);
    assign age_clear = (state_q == StCheck) && !err_q && csum_ok;

    dht_age_timer #(
        .AGE_W     (AGE_W),
        .CACHE_TIME(CACHE_TIME)
    ) u_age_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (age_clear),
        .enable(cache_valid_q),
        .stale (cache_stale)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            req_ready     <= 1'b0;
            dht_start     <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            code_q        <= '0;
            byte1_q       <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            cache_valid_q <= 1'b0;
        end else begin
            dht_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        code_q    <= req_code;
                        state_q   <= StDecode;
                    end
                end
                StDecode: begin
                    if (!code_valid(code_q)) begin
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_INVALID;
                        byte1_q  <= '0;
                        state_q  <= StSend0;
                    end else if (cache_valid_q && !cache_stale) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rsp_code(code_q);
                        byte1_q  <= rsp_value(data_q, code_q);
                        state_q  <= StSend0;
                    end else begin
                        dht_start <= 1'b1;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    cnt_q   <= '0;
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    // done takes priority over a timeout expiring in the same cycle
                    if (dht_done) begin
                        data_q  <= {hum_int, hum_float, temp_int, temp_float, check_sum};
                        err_q   <= dht_error;
                        state_q <= StCheck;
                    end else if (cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
                        cache_valid_q <= 1'b0;
                        tx_valid      <= 1'b1;
                        tx_data       <= RSP_SENSOR_ERR;
                        byte1_q       <= '0;
                        state_q       <= StSend0;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                StCheck: begin
                    tx_valid <= 1'b1;
                    byte1_q  <= '0;
                    state_q  <= StSend0;
                    if (err_q) begin
                        cache_valid_q <= 1'b0;
                        tx_data       <= RSP_SENSOR_ERR;
                    end else if (!csum_ok) begin
                        cache_valid_q <= 1'b0;
                        tx_data       <= RSP_CSUM_ERR;
                    end else begin
                        cache_valid_q <= 1'b1;
                        tx_data       <= rsp_code(code_q);
                        byte1_q       <= rsp_value(data_q, code_q);
                    end
                end
                StSend0: begin
                    if (tx_ready) begin
                        tx_data <= byte1_q;
                        state_q <= StSend1;
                    end
                end
                StSend1: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
